mem_access_stage: RTL and testbench
===================================

# mem_access_stage

MEM-stage data-memory access unit sitting directly upstream of the MEM/WB pipeline register. It takes the EX/MEM view of the current instruction (ALU result as address, rb as store data, load/store control), runs a req/ack transaction against the data RAM, aligns and extends load data, and produces `out_Memdata` for MEM/WB. While a transaction is outstanding it stalls the pipeline; non-memory instructions pass with zero added latency.

## Interface
- `TIMEOUT`, 16: maximum REQ-state cycles without `in_mack` before the access is abandoned (≥1).
- `in_CLK` input 1: clock, rising edge.
- `in_CLR_n` input 1: asynchronous, active-low reset. One clock; reset is asynchronous and active-low.
- `in_valid` input 1: EX/MEM holds a live instruction.
- `in_memread` input 1: load.
- `in_memwrite` input 1: store. memread and memwrite both high is treated as a load.
- `in_size` input 2: 00 byte, 01 half, 10/11 word.
- `in_unsigned` input 1: zero-extend loads (else sign-extend).
- `in_addr` input 32: byte address (EX/MEM R).
- `in_wdata` input 32: store data (EX/MEM rb).
- `out_stall` output 1: freeze PC/IF/ID/EX/EX-MEM and hold MEM/WB EN low.
- `out_Memdata` output 32: aligned/extended load data for MEM/WB.
- `out_misalign` output 1: current memory op is misaligned (combinational).
- `out_timeout` output 1: sticky, an access timed out.
- `out_mreq` output 1: RAM request.
- `out_mwe` output 1: RAM write.
- `out_maddr` output 32: word address (`in_addr` with [1:0]=00).
- `out_mbe` output 4: byte enables.
- `out_mwdata` output 32: lane-replicated store data.
- `in_mack` input 1: RAM acknowledge; read data valid in same cycle.
- `in_mrdata` input 32: RAM read word.

## Operation
- Memory op = `in_valid & (in_memread | in_memwrite)`. Misaligned = half with addr[0]=1, or word with addr[1:0]≠0.
- FSM states IDLE, REQ, DONE.
  - IDLE: memory op, aligned → latch mwe/maddr/mbe/mwdata/size/unsigned/lane, go REQ. Otherwise stay.
  - REQ: `out_mreq`=1. On `in_mack`: for loads, register extended data into `out_Memdata`; go DONE. If TIMEOUT cycles have elapsed with no ack: set `out_timeout`, `out_Memdata`←0 (loads), go DONE. The wait counter clears on entry to REQ.
  - DONE: one cycle, then IDLE unconditionally. Upstream advances at this edge, so the same instruction is never re-issued.
- `out_stall` = (IDLE & memory op & aligned) | REQ. DONE and all other cases give 0.
- Misaligned op: no request and no stall. `out_misalign`=1 while presented. `out_Memdata` is unchanged.
- Byte enables (little-endian):
  - byte: 0001<<addr[1:0], wdata = {4{wdata[7:0]}}
  - half: 0011<<(2·addr[1]), wdata = {2{wdata[15:0]}}
  - word: 1111, wdata passed through.
- Load extract: byte = mrdata[8·lane+7 : 8·lane], half = mrdata[16·addr[1]+15 : 16·addr[1]], each extended to 32 bits per `in_unsigned`. Word is passed through.
- Stores leave `out_Memdata` unchanged.
- `out_mwe`, `out_maddr`, `out_mbe`, `out_mwdata` come from registers latched at IDLE→REQ and are stable throughout REQ. They are 0 when not in REQ.
- `in_mack` outside REQ is ignored.

## Timing
- Reset (async, any state including mid-REQ): state IDLE, `out_mreq`/`out_mwe`=0, `out_maddr`/`out_mbe`/`out_mwdata`=0, `out_Memdata`=0, `out_timeout`=0, wait counter 0. A pending RAM ack after reset is ignored.
- Access with ack after k REQ cycles (k≥1): stall cycles = 1 + k. Data is valid in DONE, k+1 cycles after acceptance, and is captured by MEM/WB at the end of DONE.
- Minimum: accept at cycle T, ack at T+1, DONE at T+2, giving 2 stall cycles.
- Timeout: ack absent for TIMEOUT REQ cycles. DONE follows the TIMEOUT-th REQ cycle, giving stall = 1+TIMEOUT.
- Back-to-back memory ops: the next one is accepted in the IDLE cycle following DONE.

## Test plan
- Word load, addr 0x100, ack on first REQ cycle, mrdata 0xDEADBEEF → `out_stall` high 2 cycles, `out_mbe`=1111, `out_maddr`=0x100, `out_Memdata`=0xDEADBEEF in DONE.
- Signed byte load addr 0x103, mrdata 0x80FF_0000 → `out_Memdata`=0xFFFFFF80. Same access with `in_unsigned`=1 → 0x00000080.
- Half store addr 0x22, wdata 0x1234ABCD → `out_mwe`=1, `out_mbe`=1100, `out_mwdata`=0xABCDABCD, `out_maddr`=0x20. `out_Memdata` unchanged.
- Word load addr 0x102 → `out_misalign`=1, `out_mreq` never asserted, `out_stall`=0.
- Load with no ack, TIMEOUT=4 → `out_stall` high 5 cycles, `out_timeout` set and held, `out_Memdata`=0. The next aligned load completes normally.
- Assert `in_CLR_n` low during REQ → `out_mreq`, `out_stall`, and all outputs go to 0 immediately. A late `in_mack` after release has no effect.

Source files
------------

// File: rtl/mem_access_stage.sv
// mem_access_stage: MEM-stage data-memory access unit.
// Runs one req/ack RAM transaction per aligned load/store and stalls the
// pipeline while it is outstanding. It aligns and extends load data for
// MEM/WB, and abandons an access that gets no acknowledge within TIMEOUT
// request cycles.
module mem_access_stage #(
    parameter int TIMEOUT = 16
) (
    input  logic        in_CLK,
    input  logic        in_CLR_n,
    input  logic        in_valid,
    input  logic        in_memread,
    input  logic        in_memwrite,
    input  logic [1:0]  in_size,
    input  logic        in_unsigned,
    input  logic [31:0] in_addr,
    input  logic [31:0] in_wdata,
    output logic        out_stall,
    output logic [31:0] out_Memdata,
    output logic        out_misalign,
    output logic        out_timeout,
    output logic        out_mreq,
    output logic        out_mwe,
    output logic [31:0] out_maddr,
    output logic [3:0]  out_mbe,
    output logic [31:0] out_mwdata,
    input  logic        in_mack,
    input  logic [31:0] in_mrdata
);

    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

    typedef enum logic [1:0] {ST_IDLE, ST_REQ, ST_DONE} state_t;

    state_t        r_state;
    state_t        w_next;
    logic          r_we;
    logic          r_load;
    logic          r_uns;
    logic [1:0]    r_size;
    logic [1:0]    r_lane;
    logic [31:0]   r_maddr;
    logic [3:0]    r_be;
    logic [31:0]   r_wdata;
    logic [CW-1:0] r_cnt;
    logic [31:0]   r_memdata;
    logic          r_timeout;

    logic          w_memop;
    logic          w_go;
    logic          w_expire;
    logic [3:0]    w_be;
    logic [31:0]   w_wdata;

    // Pick the addressed byte/half out of the RAM word and extend it to 32 bits.
    function automatic logic [31:0] f_extract(input logic [31:0] d, input logic [1:0] sz,
                                              input logic uns, input logic [1:0] lane);
        logic [7:0]  b;
        logic [15:0] h;
        b = d[8*lane +: 8];
        h = d[16*lane[1] +: 16];
        case (sz)
            2'b00:   f_extract = uns ? {24'd0, b} : {{24{b[7]}}, b};
            2'b01:   f_extract = uns ? {16'd0, h} : {{16{h[15]}}, h};
            default: f_extract = d;
        endcase
    endfunction

    assign w_memop      = in_valid & (in_memread | in_memwrite);
    assign out_misalign = w_memop & (((in_size == 2'b01) & in_addr[0]) |
                                     (in_size[1] & (in_addr[1:0] != 2'b00)));
    assign w_go         = w_memop & ~out_misalign;
    assign w_expire     = ~in_mack & (r_cnt == CNT_LAST);

    // Lane byte enables and replicated store data for the presented op.
    always_comb begin
        w_be    = 4'b1111;
        w_wdata = in_wdata;
        case (in_size)
            2'b00: begin
                w_be    = 4'b0001 << in_addr[1:0];
                w_wdata = {4{in_wdata[7:0]}};
            end
            2'b01: begin
                w_be    = 4'b0011 << {in_addr[1], 1'b0};
                w_wdata = {2{in_wdata[15:0]}};
            end
            default: ;
        endcase
    end

    // Next-state logic: DONE always lasts exactly one cycle.
    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: if (w_go) w_next = ST_REQ;
            ST_REQ:  if (in_mack || w_expire) w_next = ST_DONE;
            default: w_next = ST_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge in_CLK or negedge in_CLR_n) begin
        if (!in_CLR_n) r_state <= ST_IDLE;
        else           r_state <= w_next;
    end

    // Latch the request fields when an aligned op is accepted.
    always_ff @(posedge in_CLK or negedge in_CLR_n) begin
        if (!in_CLR_n) begin
            r_we    <= 1'b0;
            r_load  <= 1'b0;
            r_uns   <= 1'b0;
            r_size  <= 2'b00;
            r_lane  <= 2'b00;
            r_maddr <= 32'd0;
            r_be    <= 4'd0;
            r_wdata <= 32'd0;
        end else if (r_state == ST_IDLE && w_go) begin
            r_we    <= ~in_memread;
            r_load  <= in_memread;
            r_uns   <= in_unsigned;
            r_size  <= in_size;
            r_lane  <= in_addr[1:0];
            r_maddr <= {in_addr[31:2], 2'b00};
            r_be    <= w_be;
            r_wdata <= w_wdata;
        end
    end

    // Wait counter: zero outside REQ, counts REQ cycles without ack.
    always_ff @(posedge in_CLK or negedge in_CLR_n) begin
        if (!in_CLR_n)              r_cnt <= '0;
        else if (r_state == ST_REQ) r_cnt <= r_cnt + 1'b1;
        else                        r_cnt <= '0;
    end

    // Load result capture and sticky timeout flag.
    always_ff @(posedge in_CLK or negedge in_CLR_n) begin
        if (!in_CLR_n) begin
            r_memdata <= 32'd0;
            r_timeout <= 1'b0;
        end else if (r_state == ST_REQ) begin
            if (in_mack) begin
                if (r_load) r_memdata <= f_extract(in_mrdata, r_size, r_uns, r_lane);
            end else if (w_expire) begin
                r_timeout <= 1'b1;
                if (r_load) r_memdata <= 32'd0;
            end
        end
    end

    assign out_mreq    = (r_state == ST_REQ);
    assign out_stall   = in_CLR_n & (((r_state == ST_IDLE) & w_go) | (r_state == ST_REQ));
    assign out_mwe     = out_mreq & r_we;
    assign out_maddr   = out_mreq ? r_maddr : 32'd0;
    assign out_mbe     = out_mreq ? r_be    : 4'd0;
    assign out_mwdata  = out_mreq ? r_wdata : 32'd0;
    assign out_Memdata = r_memdata;
    assign out_timeout = r_timeout;

endmodule

// File: tb/tb_mem_access_stage.sv
// Testbench for mem_access_stage: directed cases followed by randomized
// transactions compared against a transaction-level reference model.
module tb_mem_access_stage;

    localparam int TO = 4;

    logic        in_CLK = 1'b0;
    logic        in_CLR_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_memread = 1'b0;
    logic        in_memwrite = 1'b0;
    logic [1:0]  in_size = 2'b00;
    logic        in_unsigned = 1'b0;
    logic [31:0] in_addr = 32'd0;
    logic [31:0] in_wdata = 32'd0;
    logic        in_mack = 1'b0;
    logic [31:0] in_mrdata = 32'd0;
    logic        out_stall, out_misalign, out_timeout, out_mreq, out_mwe;
    logic [31:0] out_Memdata, out_maddr, out_mwdata;
    logic [3:0]  out_mbe;

    int          n_checks = 0;
    int          n_fail = 0;
    logic [31:0] exp_mem = 32'd0;
    logic        exp_to = 1'b0;

    mem_access_stage #(.TIMEOUT(TO)) dut (
        .in_CLK(in_CLK), .in_CLR_n(in_CLR_n), .in_valid(in_valid),
        .in_memread(in_memread), .in_memwrite(in_memwrite), .in_size(in_size),
        .in_unsigned(in_unsigned), .in_addr(in_addr), .in_wdata(in_wdata),
        .out_stall(out_stall), .out_Memdata(out_Memdata), .out_misalign(out_misalign),
        .out_timeout(out_timeout), .out_mreq(out_mreq), .out_mwe(out_mwe),
        .out_maddr(out_maddr), .out_mbe(out_mbe), .out_mwdata(out_mwdata),
        .in_mack(in_mack), .in_mrdata(in_mrdata)
    );

    always #5 in_CLK = ~in_CLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Reference load result: pick the addressed lane arithmetically and extend.
    function automatic logic [31:0] ref_load(input logic [31:0] rd, input logic [1:0] sz,
                                             input logic uns, input logic [31:0] a);
        logic [31:0] v;
        if (sz == 2'd0) begin
            v = (rd >> (8 * (a % 4))) & 32'hFF;
            if (!uns && v >= 32'd128) v = v - 32'd256;
        end else if (sz == 2'd1) begin
            v = (rd >> (16 * ((a % 4) / 2))) & 32'hFFFF;
            if (!uns && v >= 32'd32768) v = v - 32'd65536;
        end else begin
            v = rd;
        end
        return v;
    endfunction

    task automatic idle_cycle();
        @(negedge in_CLK);
        in_valid = 1'b0; in_memread = 1'b0; in_memwrite = 1'b0; in_mack = 1'b0;
        #1;
        chk("idle_stall", 32'(out_stall), 32'd0);
        chk("idle_mreq", 32'(out_mreq), 32'd0);
    endtask

    // One EX/MEM instruction; ack arrives on REQ cycle k (k > TO means never).
    task automatic access(input logic [31:0] a, input logic [1:0] sz, input logic uns,
                          input logic rd, input logic wr, input int k,
                          input logic [31:0] rdata, input logic [31:0] wdata);
        logic        mis, is_load;
        logic [3:0]  e_be;
        logic [31:0] e_wd;
        int          c;
        mis     = (sz == 2'd1 && (a % 2) != 0) || (sz >= 2'd2 && (a % 4) != 0);
        is_load = rd;
        if (sz == 2'd0) begin
            e_be = 4'(1 << (a % 4));
            e_wd = (wdata & 32'hFF) * 32'h0101_0101;
        end else if (sz == 2'd1) begin
            e_be = ((a % 4) >= 2) ? 4'b1100 : 4'b0011;
            e_wd = (wdata & 32'hFFFF) * 32'h0001_0001;
        end else begin
            e_be = 4'b1111;
            e_wd = wdata;
        end
        @(negedge in_CLK);
        in_valid = 1'b1; in_memread = rd; in_memwrite = wr; in_size = sz;
        in_unsigned = uns; in_addr = a; in_wdata = wdata; in_mack = 1'b0;
        #1;
        chk("misalign", 32'(out_misalign), 32'(mis));
        if (mis) begin
            chk("mis_stall", 32'(out_stall), 32'd0);
            repeat (2) begin
                @(negedge in_CLK); #1;
                chk("mis_mreq", 32'(out_mreq), 32'd0);
                chk("mis_stall2", 32'(out_stall), 32'd0);
            end
            chk("mis_memdata", out_Memdata, exp_mem);
            return;
        end
        chk("accept_stall", 32'(out_stall), 32'd1);
        chk("accept_mreq", 32'(out_mreq), 32'd0);
        c = 0;
        while (1) begin
            c++;
            @(negedge in_CLK);
            in_mack = (c == k);
            in_mrdata = (c == k) ? rdata : $urandom;
            #1;
            chk("req_mreq", 32'(out_mreq), 32'd1);
            chk("req_stall", 32'(out_stall), 32'd1);
            chk("req_mwe", 32'(out_mwe), 32'(!is_load));
            chk("req_maddr", out_maddr, a & 32'hFFFF_FFFC);
            chk("req_mbe", 32'(out_mbe), 32'(e_be));
            chk("req_mwdata", out_mwdata, e_wd);
            chk("req_memdata", out_Memdata, exp_mem);
            if (c == k || c == TO) break;
        end
        if (c == k) begin
            if (is_load) exp_mem = ref_load(rdata, sz, uns, a);
        end else begin
            exp_to = 1'b1;
            if (is_load) exp_mem = 32'd0;
        end
        @(negedge in_CLK);
        in_mack = 1'b0;
        in_mrdata = $urandom;
        #1;
        chk("done_stall", 32'(out_stall), 32'd0);
        chk("done_mreq", 32'(out_mreq), 32'd0);
        chk("done_mbe", 32'(out_mbe), 32'd0);
        chk("done_memdata", out_Memdata, exp_mem);
        chk("done_timeout", 32'(out_timeout), 32'(exp_to));
    endtask

    initial begin
        repeat (2) @(negedge in_CLK);
        #1;
        chk("rst_mreq", 32'(out_mreq), 32'd0);
        chk("rst_memdata", out_Memdata, 32'd0);
        chk("rst_timeout", 32'(out_timeout), 32'd0);
        chk("rst_maddr", out_maddr, 32'd0);
        in_CLR_n = 1'b1;
        idle_cycle();

        // Directed cases
        access(32'h100, 2'd2, 1'b0, 1'b1, 1'b0, 1, 32'hDEADBEEF, 32'h0);
        access(32'h103, 2'd0, 1'b0, 1'b1, 1'b0, 1, 32'h80FF_0000, 32'h0);
        access(32'h103, 2'd0, 1'b1, 1'b1, 1'b0, 2, 32'h80FF_0000, 32'h0);
        access(32'h22,  2'd1, 1'b0, 1'b0, 1'b1, 1, 32'h0, 32'h1234ABCD);
        idle_cycle();
        access(32'h102, 2'd2, 1'b0, 1'b1, 1'b0, 1, 32'h0, 32'h0);
        idle_cycle();
        access(32'h40,  2'd2, 1'b0, 1'b1, 1'b1, TO + 1, 32'h0, 32'h0);
        access(32'h44,  2'd1, 1'b1, 1'b1, 1'b0, 3, 32'h8765_4321, 32'h0);

        // Asynchronous reset in the middle of REQ
        @(negedge in_CLK);
        in_valid = 1'b1; in_memread = 1'b1; in_memwrite = 1'b0;
        in_size = 2'd2; in_addr = 32'h200;
        repeat (2) @(negedge in_CLK);
        #2;
        in_CLR_n = 1'b0;
        #1;
        chk("arst_mreq", 32'(out_mreq), 32'd0);
        chk("arst_stall", 32'(out_stall), 32'd0);
        chk("arst_maddr", out_maddr, 32'd0);
        chk("arst_memdata", out_Memdata, 32'd0);
        chk("arst_timeout", 32'(out_timeout), 32'd0);
        exp_mem = 32'd0; exp_to = 1'b0;
        @(negedge in_CLK);
        in_valid = 1'b0; in_memread = 1'b0;
        in_CLR_n = 1'b1;
        in_mack = 1'b1; in_mrdata = 32'hCAFEF00D;
        @(negedge in_CLK); #1;
        chk("late_ack_mreq", 32'(out_mreq), 32'd0);
        chk("late_ack_memdata", out_Memdata, 32'd0);
        in_mack = 1'b0;
        idle_cycle();

        // Randomized transactions
        for (int i = 0; i < 60; i++) begin
            logic [31:0] a;
            logic [1:0]  sz;
            logic        rd, wr;
            a  = 32'h1000 + $urandom_range(0, 255);
            sz = 2'($urandom_range(0, 3));
            rd = 1'($urandom_range(0, 1));
            wr = rd ? 1'($urandom_range(0, 1)) : 1'b1;
            access(a, sz, 1'($urandom_range(0, 1)), rd, wr, $urandom_range(1, TO + 1),
                   $urandom, $urandom);
            if ($urandom_range(0, 2) == 0) idle_cycle();
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

endmodule
